// File: rtl/i2c_channel_pkg.sv
// Shared types and default constants for the NM-master / NS-slave I2C channel.
package i2c_channel_pkg;

  // Bus monitor state: IDLE between STOP (or timeout) and START, BUSY otherwise.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Default glitch-filter stability length in clk cycles (0 bypasses the filter).
  localparam int DEF_FILT_CYC    = 3;
  // Default number of SCL-low cycles in BUSY before the bus is declared stuck.
  localparam int DEF_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a stability filter for one I2C line.
// The filtered output only follows the synchronised input after it has
// differed from the current filtered value for FILT_CYC consecutive cycles.
// Everything resets to 1, the idle level of an open-drain line.
module i2c_line_filter #(
  parameter int FILT_CYC = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic sync1;
  logic sync2;

  // Two-stage synchroniser for the asynchronous bus level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  if (FILT_CYC == 0) begin : g_bypass
    assign dout = sync2;
  end else begin : g_filter
    localparam int CW = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          filt;

    // Count consecutive mismatch cycles; any matching cycle restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt  <= '0;
        filt <= 1'b1;
      end else if (sync2 != filt) begin
        if (cnt == CNT_LAST) begin
          filt <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign dout = filt;
  end

endmodule

// File: rtl/i2c_channel_nm_ms.sv
// I2C channel for NM masters and NS slaves.
// Wired-AND resolution of all open-drain drives plus a clocked bus monitor
// (START/STOP detection, bus-busy, per-master arbitration loss, optional
// SCL-stuck-low timeout enabled by the I2C_CHAN_TIMEOUT_EN macro).
// mon_state exposes the monitor FSM state for debug and checkers.
module i2c_channel_nm_ms
  import i2c_channel_pkg::*;
#(
  parameter int NM          = 2,
  parameter int NS          = 4,
  parameter int FILT_CYC    = DEF_FILT_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [NM-1:0] m_scl_oe,
  input  logic [NM-1:0] m_sda_oe,
  input  logic [NS-1:0] s_scl_oe,
  input  logic [NS-1:0] s_sda_oe,
  output logic          scl,
  output logic          sda,
  output logic          bus_busy,
  output logic          start_det,
  output logic          stop_det,
  output logic [NM-1:0] arb_lost,
  output logic          timeout,
  output state_e        mon_state
);

  logic          scl_f;
  logic          sda_f;
  logic          scl_p;
  logic          sda_p;
  logic          start_cond;
  logic          stop_cond;
  logic          scl_rise;
  logic          tmo_cond;
  logic [NM-1:0] arb_cond;
  logic [NM-1:0] active;
  state_e        state_q;
  state_e        state_d;

  // Any agent pulling low wins; the implicit pull-up gives 1 otherwise.
  assign scl = ~(|m_scl_oe | |s_scl_oe);
  assign sda = ~(|m_sda_oe | |s_sda_oe);

  i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_scl_filter (
    .clk  (clk),
    .rstn (rstn),
    .din  (scl),
    .dout (scl_f)
  );

  i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_sda_filter (
    .clk  (clk),
    .rstn (rstn),
    .din  (sda),
    .dout (sda_f)
  );

  // Previous filtered levels for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  end

  // SCL must be high in both cycles, so a cycle where SCL and SDA move
  // together is neither START nor STOP.
  assign start_cond = scl_f & scl_p &  sda_p & ~sda_f;
  assign stop_cond  = scl_f & scl_p & ~sda_p &  sda_f;
  assign scl_rise   = scl_f & ~scl_p;

  // An active master that released SDA but sees it low at SCL rise has lost.
  assign arb_cond = {NM{scl_rise & ~sda_p}} & active & ~m_sda_oe;

`ifdef I2C_CHAN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] tcnt;

  assign tmo_cond = (state_q == BUSY) && !scl_f && (tcnt == T_LAST);

  // Count SCL-low cycles while BUSY; saturate at the trip value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tcnt <= '0;
    end else if ((state_q != BUSY) || scl_f) begin
      tcnt <= '0;
    end else if (tcnt != T_LAST) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  // Timeout disabled: the comparison is constant false, TIMEOUT_CYC has no effect.
  assign tmo_cond = (TIMEOUT_CYC < 0);
`endif

  // Monitor FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Monitor FSM next state: START opens a transfer, STOP or timeout closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_cond) state_d = BUSY;
      BUSY:    if (stop_cond || tmo_cond) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mon_state = state_q;

  // Track which masters are clocking the current transfer; clears take priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= '0;
    end else begin
      active <= (active | ({NM{state_q == BUSY}} & m_scl_oe))
                & ~arb_cond & ~{NM{stop_cond | tmo_cond}};
    end
  end

  // Registered monitor outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_busy  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      arb_lost  <= '0;
      timeout   <= 1'b0;
    end else begin
      bus_busy  <= (state_q == BUSY);
      start_det <= start_cond;
      stop_det  <= stop_cond;
      arb_lost  <= arb_cond;
      timeout   <= tmo_cond;
    end
  end

endmodule

// File: tb/tb_i2c_channel_nm_ms.sv
// Bench for i2c_channel_nm_ms: directed bus scenarios plus random drives,
// checked every cycle against a behavioural model of the channel.
module tb_i2c_channel_nm_ms;
  import i2c_channel_pkg::*;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int F  = 3;
  localparam int TC = 20;
`ifdef I2C_CHAN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [NM-1:0] m_scl_oe = '0;
  logic [NM-1:0] m_sda_oe = '0;
  logic [NS-1:0] s_scl_oe = '0;
  logic [NS-1:0] s_sda_oe = '0;
  logic          scl, sda, bus_busy, start_det, stop_det, timeout;
  logic [NM-1:0] arb_lost;
  state_e        mon_state;

  always #5 clk = ~clk;

  i2c_channel_nm_ms #(.NM(NM), .NS(NS), .FILT_CYC(F), .TIMEOUT_CYC(TC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_scl_oe  (m_scl_oe),
    .m_sda_oe  (m_sda_oe),
    .s_scl_oe  (s_scl_oe),
    .s_sda_oe  (s_sda_oe),
    .scl       (scl),
    .sda       (sda),
    .bus_busy  (bus_busy),
    .start_det (start_det),
    .stop_det  (stop_det),
    .arb_lost  (arb_lost),
    .timeout   (timeout),
    .mon_state (mon_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  int c_start = 0, c_stop = 0, c_tmo = 0, c_arb = 0;
  logic [NM-1:0] arb_seen = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw line history, newest first; hs[k] is the level sampled k edges ago.
  bit hs[$];
  bit hd[$];
  bit m_scl_f, m_sda_f, m_scl_p, m_sda_p;
  bit m_busy;
  bit [NM-1:0] m_act;
  int m_tcnt;
  bit e_busy, e_start, e_stop, e_tmo, e_state;
  bit [NM-1:0] e_arb;

  // Filtered level: switch only if the last F synchronised samples all disagree.
  function automatic bit filt_next(input bit cur, input bit h[$]);
    if (F == 0) return h[1];
    for (int k = 2; k <= F + 1; k++)
      if (h[k] == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_reset();
    hs.delete();
    hd.delete();
    for (int k = 0; k < 8; k++) begin
      hs.push_back(1'b1);
      hd.push_back(1'b1);
    end
    m_scl_f = 1; m_sda_f = 1; m_scl_p = 1; m_sda_p = 1;
    m_busy = 0; m_act = '0; m_tcnt = 0;
    e_busy = 0; e_start = 0; e_stop = 0; e_tmo = 0; e_state = 0; e_arb = '0;
  endtask

  task automatic model_step();
    bit start, stop, rise, tmo;
    bit [NM-1:0] arb;
    hs.push_front(~(|m_scl_oe | |s_scl_oe));
    hd.push_front(~(|m_sda_oe | |s_sda_oe));
    if (hs.size() > 8) void'(hs.pop_back());
    if (hd.size() > 8) void'(hd.pop_back());
    start = m_scl_f && m_scl_p && m_sda_p && !m_sda_f;
    stop  = m_scl_f && m_scl_p && !m_sda_p && m_sda_f;
    rise  = m_scl_f && !m_scl_p;
    tmo   = TMO_EN && m_busy && !m_scl_f && (m_tcnt == TC - 1);
    for (int i = 0; i < NM; i++)
      arb[i] = rise && m_act[i] && !m_sda_oe[i] && !m_sda_p;
    e_start = start; e_stop = stop; e_tmo = tmo; e_arb = arb; e_busy = m_busy;
    for (int i = 0; i < NM; i++) begin
      if (stop || tmo || arb[i]) m_act[i] = 0;
      else if (m_busy && m_scl_oe[i]) m_act[i] = 1;
    end
    if (!m_busy || m_scl_f) m_tcnt = 0;
    else if (m_tcnt != TC - 1) m_tcnt++;
    if (stop || tmo) m_busy = 0;
    else if (start) m_busy = 1;
    e_state = m_busy;
    m_scl_p = m_scl_f;
    m_sda_p = m_sda_f;
    m_scl_f = filt_next(m_scl_f, hs);
    m_sda_f = filt_next(m_sda_f, hd);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("bus", {30'd0, scl, sda}, {30'd0, ~(|m_scl_oe | |s_scl_oe), ~(|m_sda_oe | |s_sda_oe)});
    check("mon", {bus_busy, start_det, stop_det, timeout, arb_lost, mon_state},
                 {e_busy, e_start, e_stop, e_tmo, e_arb, e_state});
    if (start_det) c_start++;
    if (stop_det)  c_stop++;
    if (timeout)   c_tmo++;
    if (|arb_lost) c_arb++;
    arb_seen = arb_seen | arb_lost;
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a falling edge, clear of both checks and sampling.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clr_counts();
    c_start = 0; c_stop = 0; c_tmo = 0; c_arb = 0; arb_seen = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NM-1:0] zero_m;
    bit exp_busy5;
    zero_m = '0;
    #1 rstn = 1'b0;
    #1;
    check("rst_mon", {bus_busy, start_det, stop_det, timeout, arb_lost}, 0);
    check("rst_bus", {scl, sda}, 2'b11);
    wait_cyc(3);
    rstn = 1'b1;
    wait_cyc(12);

    // START timing: pulse after the 6th edge, bus_busy after the 7th.
    m_sda_oe[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("t1_pre", {start_det, bus_busy}, 2'b00);
    @(posedge clk);
    #1 check("t1_start", {start_det, bus_busy}, 2'b10);
    @(posedge clk);
    #1 check("t1_busy", {start_det, bus_busy}, 2'b01);

    // Arbitration: both clock, m0 sends 1, m1 sends 0.
    wait_cyc(2);
    m_sda_oe = 2'b11;
    m_scl_oe = 2'b11;
    wait_cyc(8);
    m_sda_oe = 2'b10;
    wait_cyc(8);
    clr_counts();
    m_scl_oe = 2'b00;
    wait_cyc(10);
    check("t3_arb", arb_seen, 2'b01);
    check("t3_arb_n", c_arb, 1);

    // STOP: release SDA while SCL high.
    clr_counts();
    m_sda_oe = 2'b00;
    wait_cyc(10);
    check("t4_stop", c_stop, 1);
    check("t4_busy", bus_busy, 0);
    check("t4_active", dut.active, zero_m);

    // Glitch: 2-cycle SDA low pulse is filtered away.
    clr_counts();
    s_sda_oe[2] = 1'b1;
    wait_cyc(2);
    s_sda_oe = '0;
    wait_cyc(10);
    check("t2_start", c_start, 0);
    check("t2_busy", bus_busy, 0);

    // Timeout: slave stretches SCL for 25 cycles inside a transfer.
    m_sda_oe[0] = 1'b1;
    wait_cyc(10);
    clr_counts();
    s_scl_oe[1] = 1'b1;
    wait_cyc(25);
    s_scl_oe = '0;
    wait_cyc(10);
    exp_busy5 = !TMO_EN;
    check("t5_tmo", c_tmo, {31'd0, TMO_EN});
    check("t5_busy", bus_busy, {31'd0, exp_busy5});
    m_sda_oe = '0;
    wait_cyc(10);

    // Reset mid-byte: monitor clears at once, resolution keeps working.
    m_sda_oe[1] = 1'b1;
    wait_cyc(10);
    m_scl_oe[1] = 1'b1;
    wait_cyc(6);
    m_sda_oe[1] = 1'b0;
    wait_cyc(3);
    rstn = 1'b0;
    #1;
    check("t6_mon", {bus_busy, start_det, stop_det, timeout, arb_lost, mon_state}, 0);
    check("t6_bus", {scl, sda}, 2'b01);
    wait_cyc(3);
    m_scl_oe = '0;
    wait_cyc(2);
    rstn = 1'b1;
    clr_counts();
    wait_cyc(12);
    check("t6_nostart", c_start, 0);

    // Random drives, checked every cycle against the model.
    for (int step = 0; step < 300; step++) begin
      m_scl_oe = ($urandom_range(0, 2) == 0) ? NM'($urandom()) : '0;
      m_sda_oe = ($urandom_range(0, 1) == 0) ? NM'($urandom()) : '0;
      s_scl_oe = ($urandom_range(0, 7) == 0) ? NS'(1 << $urandom_range(0, NS - 1)) : '0;
      s_sda_oe = ($urandom_range(0, 5) == 0) ? NS'(1 << $urandom_range(0, NS - 1)) : '0;
      wait_cyc($urandom_range(1, 12));
    end
    m_scl_oe = '0; m_sda_oe = '0; s_scl_oe = '0; s_sda_oe = '0;
    wait_cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
